// File: rtl/button_input_pio_if.sv
// rtl/button_input_pio_if.sv - Avalon-MM style register bus between a host and the button PIO
//
// Signals:
//   address     word address of the register being accessed
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, zero-extended by the slave
// Modports:
//   master  drives the request, observes readdata
//   slave   observes the request, drives readdata
interface button_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/button_input_pio.sv
// rtl/button_input_pio.sv - debounced pushbutton input PIO with edge capture and maskable irq
//
// Parameters:
//   WIDTH            number of button inputs (1..32)
//   DEBOUNCE_CYCLES  consecutive clocks a synchronized bit must disagree with its
//                    debounced value before the new level is accepted (>=1)
//   EDGE_TYPE        captured edge: 0 rising, 1 falling, 2 any
//   IDLE_LEVEL       reset level of the synchronizer and debounced bits
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   bus      register bus (slave side): 0 data RO, 1 reserved, 2 irq_mask RW,
//            3 edge_capture W1C
//   in_port  asynchronous button inputs
//   irq      level interrupt, |(edge_capture & irq_mask)
module button_input_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    button_input_pio_if.slave  bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    // Count value seen on the edge that would complete the debounce window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] debounced;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    logic             wr_stb;
    logic             mask_wr;
    logic [WIDTH-1:0] w1c_bits;

    assign wr_stb   = bus.chipselect && !bus.write_n;
    assign mask_wr  = wr_stb && (bus.address == ADDR_MASK);
    assign w1c_bits = (wr_stb && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0]
                                                              : '0;

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            // Upper write data bits have no register behind them.
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    // Per-bit debounce: the counter only runs while sync2 disagrees with the
    // accepted level, so any return to the accepted level restarts the window.
    always_comb begin
        deb_next = debounced;
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != debounced[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync2[i];
                    case (EDGE_TYPE)
                        0:       edge_set[i] = sync2[i];
                        1:       edge_set[i] = ~sync2[i];
                        default: edge_set[i] = 1'b1;
                    endcase
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= IDLE_VEC;
            sync2        <= IDLE_VEC;
            debounced    <= IDLE_VEC;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            sync1     <= in_port;
            sync2     <= sync1;
            debounced <= deb_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (mask_wr) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            // A new edge outranks a same-cycle clear so a press is never lost.
            edge_capture <= (edge_capture & ~w1c_bits) | edge_set;
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                ADDR_DATA: bus.readdata = 32'(debounced);
                ADDR_MASK: bus.readdata = 32'(irq_mask);
                ADDR_EDGE: bus.readdata = 32'(edge_capture);
                default:   bus.readdata = '0;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_button_input_pio.sv
// tb/tb_button_input_pio.sv - scoreboard bench for button_input_pio
module tb_button_input_pio;

    localparam int       W    = 4;
    localparam int       D    = 4;
    localparam int       ET   = 1;
    localparam logic     IDLE = 1'b1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    logic         irq;

    button_input_pio_if bus ();

    button_input_pio #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_TYPE      (ET),
        .IDLE_LEVEL     (IDLE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   probe = 1'b0;

    // Reference model: the accepted level of a bit follows the raw input once the
    // input, seen two clocks late, has held a new value for D samples in a row.
    logic [W-1:0] m_deb;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_ec;
    logic [W-1:0] hist[$];
    logic [W-1:0] last_d;
    int           run[W];

    function automatic void model_reset();
        m_deb  = {W{IDLE}};
        m_mask = '0;
        m_ec   = '0;
        hist.delete();
        hist.push_back({W{IDLE}});
        hist.push_back({W{IDLE}});
        last_d = {W{IDLE}};
        for (int i = 0; i < W; i++) run[i] = 0;
    endfunction

    function automatic void model_edge();
        logic [W-1:0] d;
        logic [W-1:0] cap;
        cap = '0;
        hist.push_front(in_port);
        d = hist[2];
        void'(hist.pop_back());
        for (int i = 0; i < W; i++) begin
            if (d[i] == last_d[i]) run[i] = run[i] + 1;
            else run[i] = 1;
            last_d[i] = d[i];
            if (d[i] != m_deb[i] && run[i] >= D) begin
                m_deb[i] = d[i];
                cap[i] = (ET == 2) || (ET == 0 && d[i]) || (ET == 1 && !d[i]);
            end
        end
        if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
            if (bus.address == 2'd3) m_ec = m_ec & ~bus.writedata[W-1:0];
        end
        m_ec = m_ec | cap;
    endfunction

    function automatic logic [31:0] model_read(input logic cs, input logic [1:0] a);
        if (!cs) return 32'h0;
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_ec);
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compares whatever the bus presents while a probe is open.
    always @(negedge clk) begin
        if (probe) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: readdata=%h with no expected entry", bus.readdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.readdata !== e.data || irq !== e.irq) begin
                    fails++;
                    $display("FAIL %s: readdata=%h irq=%b, expected readdata=%h irq=%b",
                             e.name, bus.readdata, irq, e.data, e.irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        probe = 1'b0;
    endtask

    task automatic drive(input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] wd);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b1, 2'd0, 32'h0);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        drive(1'b1, 1'b0, a, wd);
        tick();
    endtask

    task automatic rd_const(input logic [1:0] a, input logic [31:0] data,
                            input logic ei, input string nm);
        exp_t e;
        drive(1'b1, 1'b1, a, 32'h0);
        e.name = nm; e.data = data; e.irq = ei;
        sb.push_back(e);
        probe = 1'b1;
        tick();
    endtask

    task automatic rd_model(input logic cs, input logic [1:0] a, input string nm);
        exp_t e;
        drive(cs, 1'b1, a, 32'h0);
        e.name = nm; e.data = model_read(cs, a); e.irq = |(m_ec & m_mask);
        sb.push_back(e);
        probe = 1'b1;
        tick();
    endtask

    int hold[W];

    initial begin
        in_port = {W{1'b1}};
        drive(1'b0, 1'b1, 2'd0, 32'h0);
        reset = 1'b1;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            rd_const(2'd0, 32'hF, 1'b0, "reset_data");
            rd_const(2'd3, 32'h0, 1'b0, "reset_edge");
        end

        // Press bit 0 and hold: accepted exactly D+1 edges after first sample.
        in_port[0] = 1'b0;
        for (int j = 0; j < 6; j++) rd_const(2'd0, 32'hF, 1'b0, "press_before");
        rd_const(2'd0, 32'hE, 1'b0, "press_data");
        rd_const(2'd3, 32'h1, 1'b0, "press_edge");
        rd_const(2'd0, 32'hE, 1'b0, "press_hold");

        // Unmask, then clear.
        wr(2'd2, 32'hFFFF_FFF1);
        rd_const(2'd2, 32'h1, 1'b1, "mask_irq");
        wr(2'd3, 32'h1);
        rd_const(2'd3, 32'h0, 1'b0, "w1c_clear");

        // Release bit 0: rising edge not captured.
        in_port[0] = 1'b1;
        idle(10);
        rd_const(2'd0, 32'hF, 1'b0, "release_data");
        rd_const(2'd3, 32'h0, 1'b0, "release_edge");

        // Glitch shorter than the debounce window.
        in_port[1] = 1'b0;
        idle(3);
        in_port[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_const(2'd0, 32'hF, 1'b0, "glitch_data");
            rd_const(2'd3, 32'h0, 1'b0, "glitch_edge");
        end

        // W1C landing on the capturing edge: set wins.
        in_port[1] = 1'b0;
        idle(5);
        wr(2'd3, 32'h2);
        rd_const(2'd3, 32'h2, 1'b0, "set_wins");
        in_port[1] = 1'b1;
        idle(8);
        wr(2'd3, 32'h2);
        rd_const(2'd3, 32'h0, 1'b0, "set_wins_clear");
        rd_const(2'd1, 32'h0, 1'b0, "reserved");

        // Reset in the middle of a bit 2 debounce window.
        in_port[2] = 1'b0;
        idle(4);
        reset = 1'b1;
        model_reset();
        in_port[2] = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_const(2'd3, 32'h0, 1'b0, "rst_mid_edge");
            rd_const(2'd0, 32'hF, 1'b0, "rst_mid_data");
        end

        // Randomized traffic against the model.
        for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 10);
        for (int c = 0; c < 600; c++) begin
            int op;
            for (int i = 0; i < W; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    in_port[i] = ~in_port[i];
                    hold[i] = $urandom_range(1, 10);
                end
            end
            op = $urandom_range(0, 9);
            case (op)
                0, 1:    wr(2'd2, $urandom);
                2:       wr(2'd3, $urandom);
                3:       wr(2'($urandom_range(0, 1)), $urandom);
                9:       rd_model(1'b0, 2'($urandom_range(0, 3)), "rand_unsel");
                default: rd_model(1'b1, 2'($urandom_range(0, 3)), "rand_read");
            endcase
        end
        idle(2);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_input_pio.md
Name: button_input_pio

Overview:
- Avalon-MM slave input PIO, the read-side counterpart of the LED output PIO, for the DE-board KEY pushbuttons in the alarm-clock system.
- Synchronizes and debounces asynchronous button inputs and exposes their level to the Nios II through a data register.
- Latches qualifying edges in a write-1-to-clear edge-capture register.
- Raises a maskable level interrupt so firmware can handle set/snooze/alarm-off presses without polling.

Parameters:
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive clocks a synchronized bit must differ from its debounced value before the change is accepted (>=1; 1 ms at 50 MHz).
- EDGE_TYPE, 1: captured edge: 0 rising, 1 falling, 2 any.
- IDLE_LEVEL, 1: reset value of the synchronizer and debounced bits (KEYs idle high).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous button inputs.
- readdata  output  32  read data, zero-extended above WIDTH.
- irq  output  1  active-high level interrupt.

Behaviour:
- Reset (async, active-high):
  - sync1, sync2 and debounced go to {WIDTH{IDLE_LEVEL}}.
  - Debounce counters go to 0; irq_mask and edge_capture go to 0.
  - irq = 0; readdata = 0 for address 0 when IDLE_LEVEL = 0, otherwise the idle data value.
  - Reset mid-debounce discards the pending change; no edge is captured on reset release.
- Synchronizer: two flops per bit. sync1 <= in_port, sync2 <= sync1.
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES)+1:
  - If sync2 == debounced, counter <= 0.
  - Otherwise counter increments; on the edge where it would reach DEBOUNCE_CYCLES, debounced <= sync2 and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES clocks (as seen at sync2) resets the count and is never accepted.
  - Latency: an in_port change first sampled at edge k reaches debounced at edge k+1+DEBOUNCE_CYCLES.
- Edge detect, on the same edge debounced[i] changes:
  - EDGE_TYPE 0: 0->1 sets edge_capture[i].
  - EDGE_TYPE 1: 1->0 sets edge_capture[i].
  - EDGE_TYPE 2: either direction sets edge_capture[i].
  - Bits are sticky until cleared.
- Write strobe = chipselect && !write_n. Read is zero-wait-state, combinational from registers, no side effects.
- Register map (word address):
  - 0, data: RO, returns debounced; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2, irq_mask: RW, bits [WIDTH-1:0]; upper writedata bits ignored.
  - 3, edge_capture: read returns edge_capture; a write clears every bit i with writedata[i] = 1 (W1C).
- Simultaneous edge detect and W1C on the same bit in the same cycle: the set wins and the bit stays 1, so no press is lost. Other bits clear normally.
- Unselected or out-of-map reads return 0.
- irq = |(edge_capture & irq_mask), driven combinationally from registers.
  - Asserts the cycle after the capturing edge.
  - Deasserts the cycle after a W1C or mask write removes the last enabled pending bit.
- Input changes faster than debounce produce no capture; input held constant produces exactly one capture.

Test Plan:
- Reset then release, inputs idle high, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 -> read addr0 = 0xF, addr3 = 0x0, irq = 0 for 20 cycles.
- Drive in_port[0] low at edge k and hold -> debounced[0] = 0 at edge k+5; addr0 reads 0xE and addr3 reads 0x1 from then on; irq stays 0 (mask 0).
- Write addr2 = 0x1 with edge_capture[0] = 1 -> irq = 1 next cycle. Write addr3 = 0x1 -> irq = 0 next cycle, addr3 reads 0x0.
- Pulse in_port[1] low for 3 cycles, then high -> addr0 stays 0xF, addr3 stays 0x0, irq stays 0.
- Time the W1C write to addr3 (writedata 0x2) on the exact edge bit 1 captures a falling edge -> addr3 reads 0x2 afterwards (set wins).
- Assert reset while bit 2 is mid-count (counter = 2), then release with in_port[2] already high -> no capture, addr3 = 0x0, addr0 = 0xF.
